// File: rtl/sscoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sscoreboard_pkg
// Description : Shared types for the decode->execute issue scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package sscoreboard_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        UNIT_ALU    = 2'd0,
        UNIT_LOAD   = 2'd1,
        UNIT_MULDIV = 2'd2
    } unit_e;

    typedef enum logic [1:0] {
        SC_NONE   = 2'd0,
        SC_RAW    = 2'd1,
        SC_WAW    = 2'd2,
        SC_STRUCT = 2'd3
    } stall_cause_e;

    // Only long-latency units own a destination in the scoreboard; the
    // undefined encoding 3 is treated like a single-cycle ALU op.
    function automatic logic is_tracked(input logic [1:0] unit);
        return (unit == UNIT_LOAD) || (unit == UNIT_MULDIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sscoreboard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sscoreboard_ctrl_if
// Description : Decode/writeback/stall bundle between decode and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
interface sscoreboard_ctrl_if #(
    parameter int NUM_REGS = 32
);
    import sscoreboard_pkg::*;

    // decode slot
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic                  id_writes_rd;
    logic [1:0]            id_unit;
    logic                  flush;
    // writebacks from long-latency units
    logic                  ld_wb_valid;
    logic [REG_ADDR_W-1:0] ld_wb_rd;
    logic                  md_wb_valid;
    logic [REG_ADDR_W-1:0] md_wb_rd;
    // scheduler outputs
    logic                  stall_pipeline;
    logic [1:0]            stall_cause;
    logic                  issue_fire;
    logic [NUM_REGS-1:0]   pending_mask;
    logic [3:0]            ld_outstanding;
    logic                  md_busy;
    logic                  idle;
    logic                  sb_error;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
               id_rd_addr, id_writes_rd, id_unit, flush,
               ld_wb_valid, ld_wb_rd, md_wb_valid, md_wb_rd,
        input  stall_pipeline, stall_cause, issue_fire, pending_mask,
               ld_outstanding, md_busy, idle, sb_error
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
               id_rd_addr, id_writes_rd, id_unit, flush,
               ld_wb_valid, ld_wb_rd, md_wb_valid, md_wb_rd,
        output stall_pipeline, stall_cause, issue_fire, pending_mask,
               ld_outstanding, md_busy, idle, sb_error
    );

endinterface
`default_nettype wire

// File: rtl/sscb_pending_file.sv
`default_nettype none
// ============================================================================
// Module      : sscb_pending_file
// Description : Per-register pending bits with owning-unit tags. One set port
//               (issue) and two clear ports (load and MUL/DIV writeback).
// Revision    : 1.0 - initial release
// ============================================================================
module sscb_pending_file
    import sscoreboard_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_set_en,
    input  logic [REG_ADDR_W-1:0] i_set_addr,
    input  logic [1:0]            i_set_tag,
    input  logic                  i_ld_clr_en,
    input  logic [REG_ADDR_W-1:0] i_ld_clr_addr,
    input  logic                  i_md_clr_en,
    input  logic [REG_ADDR_W-1:0] i_md_clr_addr,
    output logic [NUM_REGS-1:0]   o_pending,
    output logic [NUM_REGS-1:0]   o_eff_pending,
    output logic                  o_tag_err
);

    logic [NUM_REGS-1:0] r_pending;
    logic [1:0]          r_tag [NUM_REGS];
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic                w_ld_err;
    logic                w_md_err;

    // One-hot set/clear masks; x0 can never become pending.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_en)    w_set_mask[i_set_addr]    = 1'b1;
        if (i_ld_clr_en) w_clr_mask[i_ld_clr_addr] = 1'b1;
        if (i_md_clr_en) w_clr_mask[i_md_clr_addr] = 1'b1;
        w_set_mask[0] = 1'b0;
        w_clr_mask[0] = 1'b0;
    end

    // A writeback to a live register must hit a pending bit owned by its unit.
    always_comb begin
        w_ld_err  = i_ld_clr_en && (i_ld_clr_addr != '0) &&
                    (!r_pending[i_ld_clr_addr] || (r_tag[i_ld_clr_addr] != UNIT_LOAD));
        w_md_err  = i_md_clr_en && (i_md_clr_addr != '0) &&
                    (!r_pending[i_md_clr_addr] || (r_tag[i_md_clr_addr] != UNIT_MULDIV));
        o_tag_err = w_ld_err || w_md_err;
    end

    // Scoreboard state; a new owner set in the same cycle beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_tag[i] <= UNIT_ALU;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_set_mask[i])      r_tag[i] <= i_set_tag;
                else if (w_clr_mask[i]) r_tag[i] <= UNIT_ALU;
            end
        end
    end

    assign o_pending     = r_pending;
    assign o_eff_pending = r_pending & ~w_clr_mask;

endmodule
`default_nettype wire

// File: rtl/sscoreboard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sscoreboard_ctrl
// Description : Decode->execute issue scheduler. Detects RAW/WAW hazards
//               against long-latency destinations and structural hazards on
//               the MUL/DIV unit and load slots; drives the pipeline stall.
// Revision    : 1.0 - initial release
// ============================================================================
module sscoreboard_ctrl
    import sscoreboard_pkg::*;
#(
    parameter int MAX_LD   = 4,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    sscoreboard_ctrl_if.slave bus
);

    localparam int                c_LD_W   = 4;
    localparam logic [c_LD_W-1:0] c_MAX_LD = c_LD_W'(MAX_LD);

    logic [c_LD_W-1:0]   r_ld_cnt;
    logic                r_md_busy;
    logic                r_sb_error;

    logic [NUM_REGS-1:0] w_pending;
    logic [NUM_REGS-1:0] w_eff;
    logic                w_tag_err;
    logic                w_tracked;
    logic                w_raw;
    logic                w_waw;
    logic                w_strct;
    logic                w_hazard;
    logic                w_live;
    logic                w_stall;
    logic                w_fire;
    logic [1:0]          w_cause;
    logic                w_set_en;
    logic                w_ld_inc;
    logic                w_ld_under;
    logic                w_md_under;
    logic [c_LD_W-1:0]   w_ld_next;

    sscb_pending_file #(
        .NUM_REGS (NUM_REGS)
    ) u_pending (
        .clk           (clk),
        .rst           (rst),
        .i_set_en      (w_set_en),
        .i_set_addr    (bus.id_rd_addr),
        .i_set_tag     (bus.id_unit),
        .i_ld_clr_en   (bus.ld_wb_valid),
        .i_ld_clr_addr (bus.ld_wb_rd),
        .i_md_clr_en   (bus.md_wb_valid),
        .i_md_clr_addr (bus.md_wb_rd),
        .o_pending     (w_pending),
        .o_eff_pending (w_eff),
        .o_tag_err     (w_tag_err)
    );

    // Hazard detection and issue decision; same-cycle writebacks are forwarded.
    always_comb begin
        w_tracked = is_tracked(bus.id_unit);
        w_raw     = (bus.id_uses_rs1 && (bus.id_rs1_addr != '0) && w_eff[bus.id_rs1_addr]) ||
                    (bus.id_uses_rs2 && (bus.id_rs2_addr != '0) && w_eff[bus.id_rs2_addr]);
        w_waw     = bus.id_writes_rd && (bus.id_rd_addr != '0) && w_tracked &&
                    w_eff[bus.id_rd_addr];
        w_strct   = ((bus.id_unit == UNIT_MULDIV) && r_md_busy && !bus.md_wb_valid) ||
                    ((bus.id_unit == UNIT_LOAD) && (r_ld_cnt == c_MAX_LD) && !bus.ld_wb_valid);
        w_hazard  = w_raw || w_waw || w_strct;
        w_live    = !rst && bus.id_valid && !bus.flush;
        w_stall   = w_live && w_hazard;
        w_fire    = w_live && !w_hazard;
        if (!w_stall)   w_cause = SC_NONE;
        else if (w_raw) w_cause = SC_RAW;
        else if (w_waw) w_cause = SC_WAW;
        else            w_cause = SC_STRUCT;
        w_set_en  = w_fire && w_tracked && bus.id_writes_rd && (bus.id_rd_addr != '0);
    end

    // Next outstanding-load count; a stray writeback saturates at zero.
    always_comb begin
        w_ld_inc   = w_fire && (bus.id_unit == UNIT_LOAD);
        w_ld_under = bus.ld_wb_valid && (r_ld_cnt == '0);
        w_md_under = bus.md_wb_valid && !r_md_busy;
        if (w_ld_inc && !bus.ld_wb_valid)      w_ld_next = r_ld_cnt + 1'b1;
        else if (!w_ld_inc && bus.ld_wb_valid) w_ld_next = w_ld_under ? r_ld_cnt : r_ld_cnt - 1'b1;
        else                                   w_ld_next = r_ld_cnt;
    end

    // Unit occupancy counters and the sticky protocol-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_cnt   <= '0;
            r_md_busy  <= 1'b0;
            r_sb_error <= 1'b0;
        end else begin
            r_ld_cnt <= w_ld_next;
            if (w_fire && (bus.id_unit == UNIT_MULDIV)) r_md_busy <= 1'b1;
            else if (bus.md_wb_valid)                   r_md_busy <= 1'b0;
            if (w_ld_under || w_md_under || w_tag_err)  r_sb_error <= 1'b1;
        end
    end

    assign bus.stall_pipeline = w_stall;
    assign bus.stall_cause    = w_cause;
    assign bus.issue_fire     = w_fire;
    assign bus.pending_mask   = w_pending;
    assign bus.ld_outstanding = r_ld_cnt;
    assign bus.md_busy        = r_md_busy;
    assign bus.idle           = (w_pending == '0) && (r_ld_cnt == '0) && !r_md_busy;
    assign bus.sb_error       = r_sb_error;

endmodule
`default_nettype wire

// File: tb/tb_sscoreboard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sscoreboard_ctrl
// Description : Self-checking bench for sscoreboard_ctrl: directed scenarios
//               plus randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sscoreboard_ctrl;
    import sscoreboard_pkg::*;

    localparam int c_MAX_LD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sscoreboard_ctrl_if #(.NUM_REGS(32)) bus ();

    sscoreboard_ctrl #(.MAX_LD(c_MAX_LD), .NUM_REGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: register ownership table, counters, sticky error.
    bit [31:0]  m_pend;
    logic [1:0] m_tag [32];
    int         m_ld;
    bit         m_md;
    bit         m_err;
    int         ld_q[$];
    int         md_q[$];

    function automatic void predict(output bit st, output logic [1:0] ca, output bit fi);
        bit [31:0] eff;
        bit raw, waw, str, live;
        int u;
        eff = m_pend;
        if (bus.ld_wb_valid) eff[bus.ld_wb_rd] = 1'b0;
        if (bus.md_wb_valid) eff[bus.md_wb_rd] = 1'b0;
        eff[0] = 1'b0;
        u   = int'(bus.id_unit);
        raw = (bus.id_uses_rs1 && eff[bus.id_rs1_addr]) || (bus.id_uses_rs2 && eff[bus.id_rs2_addr]);
        waw = bus.id_writes_rd && (u == 1 || u == 2) && eff[bus.id_rd_addr];
        str = (u == 2 && m_md && !bus.md_wb_valid) || (u == 1 && m_ld == c_MAX_LD && !bus.ld_wb_valid);
        live = !rst && bus.id_valid && !bus.flush;
        st = live && (raw || waw || str);
        fi = live && !(raw || waw || str);
        ca = !st ? 2'd0 : raw ? 2'd1 : waw ? 2'd2 : 2'd3;
    endfunction

    task automatic model_step();
        bit st, fi;
        logic [1:0] ca;
        int u, rd;
        if (rst) begin
            m_pend = '0; m_ld = 0; m_md = 0; m_err = 0;
            for (int i = 0; i < 32; i++) m_tag[i] = 2'd0;
            ld_q.delete(); md_q.delete();
            return;
        end
        predict(st, ca, fi);
        u  = int'(bus.id_unit);
        rd = int'(bus.id_rd_addr);
        if (bus.ld_wb_valid) begin
            if (m_ld == 0) m_err = 1;
            if (bus.ld_wb_rd != 0 && (!m_pend[bus.ld_wb_rd] || m_tag[bus.ld_wb_rd] != 2'd1)) m_err = 1;
        end
        if (bus.md_wb_valid) begin
            if (!m_md) m_err = 1;
            if (bus.md_wb_rd != 0 && (!m_pend[bus.md_wb_rd] || m_tag[bus.md_wb_rd] != 2'd2)) m_err = 1;
        end
        if (bus.ld_wb_valid && bus.ld_wb_rd != 0) m_pend[bus.ld_wb_rd] = 1'b0;
        if (bus.md_wb_valid && bus.md_wb_rd != 0) m_pend[bus.md_wb_rd] = 1'b0;
        if (fi && (u == 1 || u == 2) && bus.id_writes_rd && rd != 0) begin
            m_pend[rd] = 1'b1;
            m_tag[rd]  = 2'(u);
        end
        if (fi && u == 1) m_ld++;
        if (bus.ld_wb_valid && m_ld > 0) m_ld--;
        if (fi && u == 2) m_md = 1;
        else if (bus.md_wb_valid) m_md = 0;
        if (fi && u == 1) ld_q.push_back(bus.id_writes_rd ? rd : 0);
        if (fi && u == 2) md_q.push_back(bus.id_writes_rd ? rd : 0);
    endtask

    always @(posedge clk) model_step();

    task automatic clear_inputs();
        bus.id_valid = 0; bus.id_rs1_addr = '0; bus.id_rs2_addr = '0;
        bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0; bus.id_rd_addr = '0;
        bus.id_writes_rd = 0; bus.id_unit = UNIT_ALU; bus.flush = 0;
        bus.ld_wb_valid = 0; bus.ld_wb_rd = '0; bus.md_wb_valid = 0; bus.md_wb_rd = '0;
    endtask

    task automatic set_id(input logic v, input logic [1:0] u, input int rd, input logic wr,
                          input int rs1, input logic u1, input int rs2, input logic u2);
        bus.id_valid = v; bus.id_unit = u; bus.id_rd_addr = 5'(rd); bus.id_writes_rd = wr;
        bus.id_rs1_addr = 5'(rs1); bus.id_uses_rs1 = u1;
        bus.id_rs2_addr = 5'(rs2); bus.id_uses_rs2 = u2;
    endtask

    task automatic do_reset();
        @(negedge clk); clear_inputs(); rst = 1;
        @(negedge clk); rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk); clear_inputs(); rst = 1;
        set_id(1, UNIT_LOAD, 3, 1, 0, 0, 0, 0);
        #1;
        checks++; if (bus.issue_fire !== 1'b0) begin errors++; $display("FAIL rst_fire: got %b want 0", bus.issue_fire); end
        checks++; if (bus.stall_pipeline !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", bus.stall_pipeline); end
        @(negedge clk); clear_inputs(); rst = 0; #1;
        checks++; if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL rst_pending: got %h want 0", bus.pending_mask); end
        checks++; if (bus.ld_outstanding !== 4'd0) begin errors++; $display("FAIL rst_ldcnt: got %0d want 0", bus.ld_outstanding); end
        checks++; if (bus.md_busy !== 1'b0 || bus.sb_error !== 1'b0) begin errors++; $display("FAIL rst_flags: got busy=%b err=%b want 0 0", bus.md_busy, bus.sb_error); end
        checks++; if (bus.idle !== 1'b1 || bus.stall_cause !== 2'd0) begin errors++; $display("FAIL rst_idle: got idle=%b cause=%0d want 1 0", bus.idle, bus.stall_cause); end
    endtask

    task automatic test_raw();
        do_reset();
        @(negedge clk); set_id(1, UNIT_LOAD, 5, 1, 0, 0, 0, 0); #1;
        checks++; if (bus.issue_fire !== 1'b1) begin errors++; $display("FAIL raw_ld_issue: got %b want 1", bus.issue_fire); end
        @(negedge clk); set_id(1, UNIT_ALU, 6, 1, 5, 1, 0, 0); #1;
        checks++; if (bus.pending_mask !== 32'h20) begin errors++; $display("FAIL raw_pending: got %h want 20", bus.pending_mask); end
        checks++; if (bus.stall_pipeline !== 1'b1 || bus.stall_cause !== SC_RAW || bus.issue_fire !== 1'b0) begin errors++; $display("FAIL raw_stall: got st=%b c=%0d f=%b want 1 1 0", bus.stall_pipeline, bus.stall_cause, bus.issue_fire); end
        @(negedge clk); #1;
        checks++; if (bus.stall_pipeline !== 1'b1) begin errors++; $display("FAIL raw_hold: got %b want 1", bus.stall_pipeline); end
        @(negedge clk); bus.ld_wb_valid = 1; bus.ld_wb_rd = 5'd5; #1;
        checks++; if (bus.stall_pipeline !== 1'b0 || bus.issue_fire !== 1'b1 || bus.stall_cause !== SC_NONE) begin errors++; $display("FAIL raw_fwd: got st=%b f=%b c=%0d want 0 1 0", bus.stall_pipeline, bus.issue_fire, bus.stall_cause); end
        @(negedge clk); clear_inputs(); #1;
        checks++; if (bus.idle !== 1'b1 || bus.sb_error !== 1'b0) begin errors++; $display("FAIL raw_done: got idle=%b err=%b want 1 0", bus.idle, bus.sb_error); end
    endtask

    task automatic test_muldiv();
        do_reset();
        @(negedge clk); set_id(1, UNIT_MULDIV, 7, 1, 1, 1, 2, 1); #1;
        checks++; if (bus.issue_fire !== 1'b1) begin errors++; $display("FAIL md_issue: got %b want 1", bus.issue_fire); end
        @(negedge clk); set_id(1, UNIT_MULDIV, 7, 1, 1, 1, 0, 0); #1;
        checks++; if (bus.md_busy !== 1'b1 || bus.stall_cause !== SC_WAW) begin errors++; $display("FAIL md_waw: got busy=%b c=%0d want 1 2", bus.md_busy, bus.stall_cause); end
        @(negedge clk); set_id(1, UNIT_MULDIV, 0, 1, 1, 1, 0, 0); #1;
        checks++; if (bus.stall_cause !== SC_STRUCT || bus.stall_pipeline !== 1'b1) begin errors++; $display("FAIL md_struct: got c=%0d st=%b want 3 1", bus.stall_cause, bus.stall_pipeline); end
        @(negedge clk); bus.md_wb_valid = 1; bus.md_wb_rd = 5'd7; #1;
        checks++; if (bus.issue_fire !== 1'b1) begin errors++; $display("FAIL md_wb_issue: got %b want 1", bus.issue_fire); end
        @(negedge clk); clear_inputs(); bus.md_wb_valid = 1; bus.md_wb_rd = 5'd0; #1;
        checks++; if (bus.md_busy !== 1'b1 || bus.pending_mask !== 32'h0) begin errors++; $display("FAIL md_setwins: got busy=%b pend=%h want 1 0", bus.md_busy, bus.pending_mask); end
        @(negedge clk); clear_inputs(); #1;
        checks++; if (bus.idle !== 1'b1 || bus.sb_error !== 1'b0) begin errors++; $display("FAIL md_done: got idle=%b err=%b want 1 0", bus.idle, bus.sb_error); end
    endtask

    task automatic test_load_slots();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); set_id(1, UNIT_LOAD, i, 1, 0, 0, 0, 0); #1;
            checks++; if (bus.issue_fire !== 1'b1) begin errors++; $display("FAIL slot_issue%0d: got %b want 1", i, bus.issue_fire); end
        end
        @(negedge clk); set_id(1, UNIT_LOAD, 8, 1, 0, 0, 0, 0); #1;
        checks++; if (bus.ld_outstanding !== 4'd4 || bus.stall_cause !== SC_STRUCT) begin errors++; $display("FAIL slot_full: got cnt=%0d c=%0d want 4 3", bus.ld_outstanding, bus.stall_cause); end
        @(negedge clk); bus.ld_wb_valid = 1; bus.ld_wb_rd = 5'd1; #1;
        checks++; if (bus.issue_fire !== 1'b1 || bus.stall_pipeline !== 1'b0) begin errors++; $display("FAIL slot_wb_issue: got f=%b st=%b want 1 0", bus.issue_fire, bus.stall_pipeline); end
        @(negedge clk); clear_inputs(); bus.ld_wb_valid = 1; bus.ld_wb_rd = 5'd2; #1;
        checks++; if (bus.ld_outstanding !== 4'd4 || bus.pending_mask !== 32'h11C) begin errors++; $display("FAIL slot_keep4: got cnt=%0d pend=%h want 4 11c", bus.ld_outstanding, bus.pending_mask); end
        @(negedge clk); bus.ld_wb_rd = 5'd3;
        @(negedge clk); bus.ld_wb_rd = 5'd4;
        @(negedge clk); bus.ld_wb_rd = 5'd8;
        @(negedge clk); clear_inputs(); #1;
        checks++; if (bus.idle !== 1'b1 || bus.sb_error !== 1'b0) begin errors++; $display("FAIL slot_drain: got idle=%b err=%b want 1 0", bus.idle, bus.sb_error); end
    endtask

    task automatic test_flush();
        do_reset();
        @(negedge clk); set_id(1, UNIT_LOAD, 9, 1, 0, 0, 0, 0);
        @(negedge clk); set_id(1, UNIT_ALU, 10, 1, 0, 0, 9, 1); bus.flush = 1; #1;
        checks++; if (bus.stall_pipeline !== 1'b0 || bus.issue_fire !== 1'b0 || bus.stall_cause !== SC_NONE) begin errors++; $display("FAIL flush_comb: got st=%b f=%b c=%0d want 0 0 0", bus.stall_pipeline, bus.issue_fire, bus.stall_cause); end
        @(negedge clk); #1;
        checks++; if (bus.pending_mask !== 32'h200 || bus.ld_outstanding !== 4'd1) begin errors++; $display("FAIL flush_state: got pend=%h cnt=%0d want 200 1", bus.pending_mask, bus.ld_outstanding); end
        @(negedge clk); clear_inputs(); bus.ld_wb_valid = 1; bus.ld_wb_rd = 5'd9;
        @(negedge clk); clear_inputs(); #1;
        checks++; if (bus.idle !== 1'b1 || bus.sb_error !== 1'b0) begin errors++; $display("FAIL flush_done: got idle=%b err=%b want 1 0", bus.idle, bus.sb_error); end
    endtask

    task automatic test_error_sticky();
        do_reset();
        @(negedge clk); bus.ld_wb_valid = 1; bus.ld_wb_rd = 5'd0;
        @(negedge clk); clear_inputs(); #1;
        checks++; if (bus.sb_error !== 1'b1 || bus.ld_outstanding !== 4'd0) begin errors++; $display("FAIL err_set: got err=%b cnt=%0d want 1 0", bus.sb_error, bus.ld_outstanding); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.sb_error !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", bus.sb_error); end
        do_reset(); #1;
        checks++; if (bus.sb_error !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", bus.sb_error); end
        @(negedge clk); set_id(1, UNIT_MULDIV, 3, 1, 0, 0, 0, 0);
        @(negedge clk); clear_inputs(); #1;
        checks++; if (bus.md_busy !== 1'b1 || bus.idle !== 1'b0) begin errors++; $display("FAIL err_mdbusy: got busy=%b idle=%b want 1 0", bus.md_busy, bus.idle); end
        do_reset(); #1;
        checks++; if (bus.idle !== 1'b1 || bus.md_busy !== 1'b0 || bus.pending_mask !== 32'h0) begin errors++; $display("FAIL err_rst_mid: got idle=%b busy=%b pend=%h want 1 0 0", bus.idle, bus.md_busy, bus.pending_mask); end
        @(negedge clk); bus.md_wb_valid = 1; bus.md_wb_rd = 5'd3;
        @(negedge clk); clear_inputs(); #1;
        checks++; if (bus.sb_error !== 1'b1) begin errors++; $display("FAIL err_late_wb: got %b want 1", bus.sb_error); end
    endtask

    task automatic test_x0();
        do_reset();
        @(negedge clk); set_id(1, UNIT_LOAD, 0, 1, 0, 0, 0, 0); #1;
        checks++; if (bus.issue_fire !== 1'b1) begin errors++; $display("FAIL x0_issue: got %b want 1", bus.issue_fire); end
        @(negedge clk); set_id(1, UNIT_ALU, 4, 1, 0, 1, 0, 1); #1;
        checks++; if (bus.stall_pipeline !== 1'b0 || bus.issue_fire !== 1'b1) begin errors++; $display("FAIL x0_nostall: got st=%b f=%b want 0 1", bus.stall_pipeline, bus.issue_fire); end
        checks++; if (bus.pending_mask !== 32'h0 || bus.ld_outstanding !== 4'd1) begin errors++; $display("FAIL x0_state: got pend=%h cnt=%0d want 0 1", bus.pending_mask, bus.ld_outstanding); end
        @(negedge clk); clear_inputs(); bus.ld_wb_valid = 1; bus.ld_wb_rd = 5'd0;
        @(negedge clk); clear_inputs(); #1;
        checks++; if (bus.idle !== 1'b1 || bus.sb_error !== 1'b0) begin errors++; $display("FAIL x0_done: got idle=%b err=%b want 1 0", bus.idle, bus.sb_error); end
    endtask

    task automatic test_random();
        bit st, fi;
        logic [1:0] ca;
        int idx;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            clear_inputs();
            rst = ($urandom_range(0, 199) == 0);
            bus.id_valid     = ($urandom_range(0, 99) < 75);
            bus.id_unit      = 2'($urandom_range(0, 2));
            bus.id_rd_addr   = 5'($urandom_range(0, 7));
            bus.id_writes_rd = ($urandom_range(0, 9) != 0);
            bus.id_rs1_addr  = 5'($urandom_range(0, 7));
            bus.id_rs2_addr  = 5'($urandom_range(0, 7));
            bus.id_uses_rs1  = $urandom_range(0, 1);
            bus.id_uses_rs2  = $urandom_range(0, 1);
            bus.flush        = ($urandom_range(0, 99) < 8);
            if (ld_q.size() > 0 && $urandom_range(0, 99) < 40) begin
                idx = $urandom_range(0, ld_q.size() - 1);
                bus.ld_wb_valid = 1; bus.ld_wb_rd = 5'(ld_q[idx]);
                ld_q.delete(idx);
            end
            if (md_q.size() > 0 && $urandom_range(0, 99) < 30) begin
                bus.md_wb_valid = 1; bus.md_wb_rd = 5'(md_q.pop_front());
            end
            #1;
            predict(st, ca, fi);
            checks++; if (bus.stall_pipeline !== st) begin errors++; $display("FAIL rnd_stall n=%0d: got %b want %b", n, bus.stall_pipeline, st); end
            checks++; if (bus.stall_cause !== ca) begin errors++; $display("FAIL rnd_cause n=%0d: got %0d want %0d", n, bus.stall_cause, ca); end
            checks++; if (bus.issue_fire !== fi) begin errors++; $display("FAIL rnd_fire n=%0d: got %b want %b", n, bus.issue_fire, fi); end
            checks++; if (bus.pending_mask !== m_pend) begin errors++; $display("FAIL rnd_pending n=%0d: got %h want %h", n, bus.pending_mask, m_pend); end
            checks++; if (bus.ld_outstanding !== 4'(m_ld)) begin errors++; $display("FAIL rnd_ldcnt n=%0d: got %0d want %0d", n, bus.ld_outstanding, m_ld); end
            checks++; if (bus.md_busy !== m_md) begin errors++; $display("FAIL rnd_mdbusy n=%0d: got %b want %b", n, bus.md_busy, m_md); end
            checks++; if (bus.sb_error !== m_err) begin errors++; $display("FAIL rnd_err n=%0d: got %b want %b", n, bus.sb_error, m_err); end
            checks++; if (bus.idle !== (m_pend == 0 && m_ld == 0 && !m_md)) begin errors++; $display("FAIL rnd_idle n=%0d: got %b", n, bus.idle); end
        end
        @(negedge clk); clear_inputs(); rst = 0;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_raw();
        test_muldiv();
        test_load_slots();
        test_flush();
        test_error_sticky();
        test_x0();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
